// File: rtl/lfsr_tap_search_pkg.sv
// Shared types and constants for the LFSR tap-search block and its
// encrypt/decrypt datapath.
package lfsr_pkg;

  localparam int unsigned LFSR_W     = 7;
  localparam logic [7:0]  SPACE_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/lfsr_tap_search_if.sv
// Bus bundle for lfsr_tap_search: start/status, data-memory read port and
// tap-table lookup port. Cycles exists only with LFSR_TAP_SEARCH_STATS_EN.
interface lfsr_tap_search_if;
  import lfsr_pkg::*;

  logic              Start;
  logic [7:0]        MemAddr;
  logic [7:0]        MemData;
  logic [7:0]        TapIdx;
  logic [7:0]        TapPattern;
  logic              Busy;
  logic              Done;
  logic              Found;
  logic [7:0]        FoundIdx;
  logic [LFSR_W-1:0] Seed;
`ifdef LFSR_TAP_SEARCH_STATS_EN
  logic [15:0]       Cycles;
`endif

  // Search engine side
  modport slave (
    input  Start, MemData, TapPattern,
    output MemAddr, TapIdx, Busy, Done, Found, FoundIdx, Seed
`ifdef LFSR_TAP_SEARCH_STATS_EN
    , output Cycles
`endif
  );

  // Controller / memory / tap-table side
  modport master (
    output Start, MemData, TapPattern,
    input  MemAddr, TapIdx, Busy, Done, Found, FoundIdx, Seed
`ifdef LFSR_TAP_SEARCH_STATS_EN
    , input Cycles
`endif
  );

endinterface

// File: rtl/lfsr_tap_search_step.sv
// One step of the 7-bit Fibonacci LFSR: shift left, feedback is the parity
// of the tapped state bits. Shared with the encrypt/decrypt datapath.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic [LFSR_W-1:0] tap,
  output logic [LFSR_W-1:0] nxt
);

  // Shift in the tapped parity at bit 0
  assign nxt = {state[LFSR_W-2:0], ^(state & tap)};

endmodule

// File: rtl/lfsr_tap_search.sv
// Recovers the tap index and 7-bit seed that produced an encrypted preamble
// of space characters. Buffers CHECK_LEN ciphertext bytes, then tries each
// tap-table entry in ascending order, one LFSR step per cycle.
// Optional: LFSR_TAP_SEARCH_STATS_EN adds the Cycles performance counter.
module lfsr_tap_search
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_TAPS  = 9,
  parameter int unsigned CHECK_LEN = 7,
  parameter logic [7:0]  BASE_ADDR = 8'h40
) (
  input logic              Clk,
  input logic              Reset_n,
  lfsr_tap_search_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(CHECK_LEN);
  localparam int unsigned CNT_W = $clog2(CHECK_LEN + 1);
  localparam logic [LFSR_W-1:0] SPACE_LO = SPACE_CHAR[LFSR_W-1:0];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [7:0]        k_q, k_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LFSR_W-1:0] ct_q [CHECK_LEN];
  logic [LFSR_W-1:0] ct_d [CHECK_LEN];
  logic [7:0]        mem_addr_q, mem_addr_d;
  logic [7:0]        found_idx_q, found_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;

  logic              accept_c;
  logic [LFSR_W-1:0] nxt_c;
  logic [LFSR_W-1:0] exp_c;
  logic [LFSR_W-1:0] seed_c;

  // Candidate next LFSR state for the tap currently presented by the table
  lfsr_step u_step (
    .state (lfsr_q),
    .tap   (bus.TapPattern[LFSR_W-1:0]),
    .nxt   (nxt_c)
  );

  // Start is only honoured when no search is in flight
  assign accept_c = bus.Start && ((state_q == IDLE) || (state_q == DONE));
  assign exp_c    = ct_q[j_q] ^ SPACE_LO;
  assign seed_c   = ct_q[0] ^ SPACE_LO;

  // Next-state and datapath updates for load and search phases
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    j_d         = j_q;
    k_d         = k_q;
    lfsr_d      = lfsr_q;
    seed_d      = seed_q;
    ct_d        = ct_q;
    mem_addr_d  = mem_addr_q;
    found_idx_d = found_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    found_d     = found_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          state_d     = LOAD;
          cnt_d       = '0;
          k_d         = '0;
          mem_addr_d  = BASE_ADDR;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          found_d     = 1'b0;
          found_idx_d = '0;
          seed_d      = '0;
        end
      end

      LOAD: begin
        // Read data trails the address by one cycle
        if (cnt_q != '0) begin
          ct_d[IDX_W'(cnt_q - CNT_W'(1))] = bus.MemData[LFSR_W-1:0];
        end
        if (cnt_q == CNT_W'(CHECK_LEN)) begin
          seed_d     = seed_c;
          lfsr_d     = seed_c;
          k_d        = '0;
          j_d        = IDX_W'(1);
          mem_addr_d = '0;
          // An all-zero seed locks the LFSR up; nothing to search
          if (seed_c == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            found_d = 1'b0;
          end else begin
            state_d = SEARCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 32'd1 < CHECK_LEN) begin
            mem_addr_d = BASE_ADDR + 8'(cnt_q) + 8'd1;
          end else begin
            mem_addr_d = '0;
          end
        end
      end

      SEARCH: begin
        if (nxt_c == exp_c) begin
          if (j_q == IDX_W'(CHECK_LEN - 1)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            found_d     = 1'b1;
            found_idx_d = k_q;
          end else begin
            lfsr_d = nxt_c;
            j_d    = j_q + IDX_W'(1);
          end
        end else if (32'(k_q) < NUM_TAPS - 1) begin
          k_d    = k_q + 8'd1;
          lfsr_d = seed_q;
          j_d    = IDX_W'(1);
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b0;
        end
      end

      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      lfsr_q      <= '0;
      seed_q      <= '0;
      ct_q        <= '{default: '0};
      mem_addr_q  <= '0;
      found_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      lfsr_q      <= lfsr_d;
      seed_q      <= seed_d;
      ct_q        <= ct_d;
      mem_addr_q  <= mem_addr_d;
      found_idx_q <= found_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
    end
  end

`ifdef LFSR_TAP_SEARCH_STATS_EN
  logic [15:0] cycles_q, cycles_d;
  logic [16:0] cycles_sum_c;

  // Busy cycles plus the first Done cycle, saturating; frozen in DONE
  always_comb begin
    cycles_d     = cycles_q;
    cycles_sum_c = 17'(cycles_q) + ((state_d == DONE) ? 17'd2 : 17'd1);
    if (accept_c) begin
      cycles_d = '0;
    end else if ((state_q == LOAD) || (state_q == SEARCH)) begin
      cycles_d = (cycles_sum_c > 17'h0FFFF) ? 16'hFFFF : cycles_sum_c[15:0];
    end
  end

  // Cycle counter register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign bus.Cycles = cycles_q;
`endif

  assign bus.MemAddr  = mem_addr_q;
  assign bus.TapIdx   = k_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Found    = found_q;
  assign bus.FoundIdx = found_idx_q;
  assign bus.Seed     = seed_q;

  // Bit 7 of ciphertext and of the tap pattern carry no information here
  logic unused_bits;
  assign unused_bits = ^{bus.MemData[7], bus.TapPattern[7]};

endmodule

// File: doc/lfsr_tap_search.md
Name: lfsr_tap_search

Overview:
- Sits directly upstream of the tap-pattern lookup table.
- Drives the table's 8-bit index and consumes the returned 8-bit tap pattern.
- Recovers which tap index and which 7-bit seed produced an encrypted preamble. The plaintext preamble is all space characters (8'h20).
- Buffers CHECK_LEN ciphertext bytes from data memory, then steps a 7-bit LFSR once per cycle for each candidate tap until one matches.

Parameters:
- NUM_TAPS, 9: number of tap-table entries searched, indices 0..NUM_TAPS-1.
- CHECK_LEN, 7: ciphertext bytes buffered and checked (range 2..16).
- BASE_ADDR, 8'h40: data-memory address of the first ciphertext byte.

Ports:
- Clk  in  1  clock; rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to begin a search.
- MemAddr  out  8  data-memory read address.
- MemData  in  8  read data, valid one cycle after MemAddr.
- TapIdx  out  8  index driven to the tap table.
- TapPattern  in  8  tap pattern returned combinationally for TapIdx.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  level; held until the next accepted Start.
- Found  out  1  valid while Done; 1 = a tap matched.
- FoundIdx  out  8  matching tap index, valid while Done && Found.
- Seed  out  7  recovered initial state (ct[0][6:0] ^ 7'h20).

Behaviour:
- Reset: state IDLE. All outputs 0, including MemAddr and TapIdx.
- States: IDLE -> LOAD -> SEARCH -> DONE.
- Start is accepted in IDLE or DONE and ignored while Busy.
- Accepting Start clears Done, Found, FoundIdx and Seed.
- LOAD:
  - For CHECK_LEN cycles, MemAddr = BASE_ADDR + n.
  - buf[n] captures MemData one cycle later. LOAD lasts CHECK_LEN+1 cycles.
  - On exit: seed = buf[0][6:0] ^ 7'h20, lfsr = seed, k = 0, j = 1.
  - If seed == 0, go straight to DONE with Found = 0. This is the lock-up case; SEARCH is skipped.
- SEARCH: one compare per cycle. TapIdx = k.
  - nxt = {lfsr[5:0], ^(lfsr & TapPattern[6:0])}.
  - exp = buf[j][6:0] ^ 7'h20; bit 7 of ciphertext is ignored.
  - Match and j == CHECK_LEN-1: go to DONE with Found = 1, FoundIdx = k.
  - Match otherwise: lfsr <= nxt, j <= j+1.
  - Mismatch and k < NUM_TAPS-1: k <= k+1, lfsr <= seed, j <= 1, all in the same cycle.
  - Mismatch and k == NUM_TAPS-1: go to DONE with Found = 0.
- Done rises the cycle after the deciding compare.
- Busy falls in that same cycle.
- Indices are searched in ascending order; the lowest matching index wins.
- Reset_n asserted mid-operation: immediate return to IDLE, all outputs 0, buffer contents don't-care.

Optional Feature:
- Macro: LFSR_TAP_SEARCH_STATS_EN.
- Defined:
  - Adds output Cycles [15:0], counting cycles from accepted Start to Done inclusive.
  - Saturates at 16'hFFFF.
  - Reset and Start clear it; it holds while in DONE.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - state enum (IDLE, LOAD, SEARCH, DONE).
  - constants SPACE_CHAR = 8'h20 and LFSR_W = 7.
- Sub-module lfsr_step:
  - Combinational.
  - Inputs: state [6:0] and tap [6:0]. Output: nxt [6:0].
  - Shared with the encrypt/decrypt datapath.

Test Plan:
1. Memory bytes 21,22,24,28,31,03,67, then Start.
   - Expect Done with Found = 1, FoundIdx = 2, Seed = 7'h01.
   - Index 0 fails at j = 4 and index 1 at j = 5; SEARCH lasts 15 cycles.
   - Done rises 24 cycles after Start.
2. Memory bytes 21,22,24,28,30,00,61 (tap 8'h60, seed 01).
   - Expect Found = 1, FoundIdx = 0, SEARCH lasts 6 cycles.
3. All seven bytes 21.
   - Every index fails at j = 1, giving 9 SEARCH cycles.
   - Expect Found = 0 and FoundIdx = 0.
4. All bytes 20 (seed 0).
   - Expect Done the cycle after LOAD with Found = 0, and TapIdx never leaving 0.
5. Start pulsed during SEARCH is ignored, and the result matches scenario 1.
   - Then Reset_n is pulsed low mid-LOAD: all outputs read 0 immediately, and a fresh Start completes scenario 1 again.
6. With LFSR_TAP_SEARCH_STATS_EN defined, scenario 1 gives Cycles = 24.
   - A back-to-back Start from DONE clears Done and Cycles on the next edge.
